// File: rtl/stream_mux_rr.sv
// Registered CH-channel stream multiplexer with a fixed-select mode and a round-robin mode.
// It takes one beat per cycle into a single-entry output register, and that register supports pop and reload in the same cycle.
module stream_mux_rr #(
  parameter int N  = 8,
  parameter int CH = 32,
  parameter int SW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*N-1:0] in_data,
  input  logic [CH-1:0]   in_valid,
  output logic [CH-1:0]   in_ready,
  input  logic            mode,
  input  logic [SW-1:0]   select,
  output logic [N-1:0]    out_data,
  output logic [SW-1:0]   out_chan,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [N-1:0]  data_p1;
  logic [SW-1:0] chan_p1;
  logic          vld_p1;
  logic [SW-1:0] ptr;

  logic          can_accept;
  logic          gnt_found;
  logic [SW-1:0] gnt;
  logic          gnt_valid;
  logic [N-1:0]  sel_data;
  logic          xfer;
  logic          hi_found, lo_found;
  logic [SW-1:0] hi_idx, lo_idx;

  // Nothing is accepted while reset is held, so in_ready stays low then
  assign can_accept = rst_n && (!vld_p1 || out_ready);

  // Round-robin search: find the lowest valid channel above ptr, otherwise the lowest valid channel overall (wrap)
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        lo_found = 1'b1;
        lo_idx   = SW'(k);
        if (SW'(k) > ptr) begin
          hi_found = 1'b1;
          hi_idx   = SW'(k);
        end
      end
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt       = '0;
    if (!mode) begin
      gnt_found = ({1'b0, select} < (SW + 1)'(CH));
      gnt       = select;
    end else if (hi_found) begin
      gnt_found = 1'b1;
      gnt       = hi_idx;
    end else if (lo_found) begin
      gnt_found = 1'b1;
      gnt       = lo_idx;
    end
  end

  always_comb begin
    in_ready  = '0;
    gnt_valid = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < CH; k++) begin
      if (gnt_found && (gnt == SW'(k))) begin
        in_ready[k] = can_accept;
        gnt_valid   = in_valid[k];
        sel_data    = in_data[k*N +: N];
      end
    end
  end

  assign xfer = gnt_found && gnt_valid && can_accept;

  // Stage p1: output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
      ptr     <= SW'(CH - 1);
    end else begin
      if (xfer) begin
        vld_p1  <= 1'b1;
        data_p1 <= sel_data;
        chan_p1 <= gnt;
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
      end
      if (xfer && mode)
        ptr <= gnt;
    end
  end

  assign out_data  = data_p1;
  assign out_chan  = chan_p1;
  assign out_valid = vld_p1;

endmodule
